// File: rtl/hamming74_serial_tx.sv
// hamming74_serial_tx
// Hamming(7,4) serial transmitter. Accepts a 4-bit word over valid/ready,
// encodes it into a 7-bit codeword (optionally corrupted by an XOR mask) and
// shifts it out MSB first (c[6] first), one bit per clock, followed by GAP
// idle cycles.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   reset    asynchronous, active-high; clears all state
//   data_in  data word d[3:0], sampled on the accepting edge only
//   valid    data_in is valid this cycle
//   ready    block can accept data_in this cycle
//   err_inj  XOR mask applied to the codeword at load time (bit i flips c[i])
//   out      serial codeword bit (IDLE_LEVEL when nothing is being sent)
//   sof      high while out carries c[6] of a word
//   busy     high in SEND or GAP
//   cw       codeword (after err_inj) most recently loaded; held after the word
module hamming74_serial_tx #(
  parameter int unsigned GAP        = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic [6:0] err_inj,
  output logic       out,
  output logic       sof,
  output logic       busy,
  output logic [6:0] cw
);

  // The gap counter only ever holds GAP-1 down to 0.
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [6:0]    sh;
  logic [2:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [6:0]    code;
  logic          accept;

  // Codeword layout: data in c[6:3], parity in c[2:0].
  always_comb begin
    code[6] = data_in[3];
    code[5] = data_in[2];
    code[4] = data_in[1];
    code[3] = data_in[0];
    code[2] = data_in[1] ^ data_in[2] ^ data_in[3];
    code[1] = data_in[0] ^ data_in[1] ^ data_in[2];
    code[0] = data_in[0] ^ data_in[2] ^ data_in[3];
    code    = code ^ err_inj;
  end

  // With GAP==0 the next word may be taken during the last bit of the
  // current one, giving a continuous bit stream.
  assign ready  = !reset && ((state == S_IDLE) ||
                             (state == S_SEND && bit_cnt == 3'd0 && GAP == 0));
  assign accept = valid && ready;

  // Outputs are decoded purely from state flops; no input reaches them.
  assign out  = (state == S_SEND) ? sh[6] : IDLE_LEVEL;
  assign sof  = (state == S_SEND) && (bit_cnt == 3'd6);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sh      <= '0;
      cw      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sh      <= code;
            cw      <= code;
            bit_cnt <= 3'd6;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          sh      <= sh << 1;
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            if (GAP > 0) begin
              gap_cnt <= GW'(GAP - 1);
              state   <= S_GAP;
            end else if (accept) begin
              sh      <= code;
              cw      <= code;
              bit_cnt <= 3'd6;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// tb_hamming74_serial_tx
// Drives two transmitters (GAP=0 and GAP=2) from shared inputs and checks
// every cycle against a queue-of-symbols reference model: each accepted word
// appends its seven bits plus GAP idle symbols; one symbol is consumed per
// clock. Directed sequences check literal bit streams, and a syndrome-based
// receiver model confirms every single-bit injected error is correctable.
module tb_hamming74_serial_tx;

  typedef struct packed {
    logic val;
    logic first;
  } ent_t;

  localparam int G2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       valid;
  logic [6:0] err_inj;

  logic       ready0, out0, sof0, busy0;
  logic [6:0] cw0;
  logic       ready1, out1, sof1, busy1;
  logic [6:0] cw1;

  int n_vec = 0;
  int n_err = 0;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [6:0] cwm0, cwm1;
  logic       got0[$];

  always #5 clk = ~clk;

  hamming74_serial_tx #(.GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .ready(ready0),
    .err_inj(err_inj), .out(out0), .sof(sof0), .busy(busy0), .cw(cw0)
  );

  hamming74_serial_tx #(.GAP(G2), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .ready(ready1),
    .err_inj(err_inj), .out(out1), .sof(sof1), .busy(busy1), .cw(cw1)
  );

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[6:3] = d;
    c[0]   = ^(d & 4'b1101);
    c[1]   = ^(d & 4'b0111);
    c[2]   = ^(d & 4'b1110);
    return c;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] r);
    return {r[2] ^ r[4] ^ r[5] ^ r[6],
            r[1] ^ r[3] ^ r[4] ^ r[5],
            r[0] ^ r[3] ^ r[5] ^ r[6]};
  endfunction

  // Receiver model: pick the single flip that clears the syndrome.
  function automatic logic [6:0] correct(input logic [6:0] r);
    logic [6:0] fixed;
    fixed = r;
    if (syndrome(r) != 3'b000)
      for (int j = 0; j < 7; j++)
        if (syndrome(r ^ (7'd1 << j)) == 3'b000) fixed = r ^ (7'd1 << j);
    return fixed;
  endfunction

  function automatic logic exp_ready(input int gap, input int n);
    return (n == 0) || (gap == 0 && n == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input int gap, input ent_t q[$],
                            input logic [6:0] cwm, input logic o, input logic s,
                            input logic b, input logic r, input logic [6:0] c);
    logic eb, eo, es;
    eb = (q.size() != 0);
    eo = eb ? q[0].val : 1'b0;
    es = eb && q[0].first;
    chk({nm, ".out"}, 32'(o), 32'(eo));
    chk({nm, ".sof"}, 32'(s), 32'(es));
    chk({nm, ".busy"}, 32'(b), 32'(eb));
    chk({nm, ".ready"}, 32'(r), 32'(exp_ready(gap, q.size())));
    chk({nm, ".cw"}, 32'(c), 32'(cwm));
  endtask

  task automatic step_model(input int gap, input logic acc, input logic [6:0] word,
                            inout ent_t q[$], inout logic [6:0] cwm);
    if (q.size() != 0) void'(q.pop_front());
    if (acc) begin
      cwm = word;
      for (int i = 6; i >= 0; i--) q.push_back('{val: word[i], first: (i == 6)});
      for (int i = 0; i < gap; i++) q.push_back('{val: 1'b0, first: 1'b0});
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic [6:0] e);
    logic a0, a1;
    logic [6:0] w;
    @(negedge clk);
    valid   = v;
    data_in = d;
    err_inj = e;
    #1;
    check_inst("g0", 0, q0, cwm0, out0, sof0, busy0, ready0, cw0);
    check_inst("g2", G2, q1, cwm1, out1, sof1, busy1, ready1, cw1);
    got0.push_back(out0);
    a0 = v && exp_ready(0, q0.size());
    a1 = v && exp_ready(G2, q1.size());
    w  = encode(d) ^ e;
    @(posedge clk);
    step_model(0, a0, w, q0, cwm0);
    step_model(G2, a1, w, q1, cwm1);
  endtask

  // Sends one word on the GAP=0 instance and returns the seven bits seen.
  task automatic send_one(input logic [3:0] d, input logic [6:0] e, output logic [6:0] rx);
    got0.delete();
    cycle(1'b1, d, e);
    repeat (7) cycle(1'b0, 4'd0, 7'd0);
    rx = '0;
    for (int i = 1; i <= 7; i++) rx = {rx[5:0], got0[i]};
  endtask

  initial begin
    logic [6:0]  rx;
    logic [13:0] pair;
    logic [6:0]  e;
    logic        v;
    logic [3:0]  d;

    reset = 1'b1; valid = 1'b0; data_in = '0; err_inj = '0;
    cwm0 = '0; cwm1 = '0;
    #1;
    chk("rst.out", 32'(out0), 32'd0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.ready", 32'(ready0), 32'd0);
    chk("rst.cw", 32'(cw0), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    send_one(4'b1011, 7'd0, rx);
    chk("seq1011", 32'(rx), 32'(7'b1011000));
    chk("cw1011", 32'(cw0), 32'(7'b1011000));
    chk("syn1011", 32'(syndrome(rx)), 32'd0);
    send_one(4'b0001, 7'd0, rx);
    chk("seq0001", 32'(rx), 32'(7'b0001011));
    send_one(4'b1111, 7'd0, rx);
    chk("seq1111", 32'(rx), 32'(7'b1111111));
    send_one(4'b0000, 7'd0, rx);
    chk("seq0000", 32'(rx), 32'(7'b0000000));
    repeat (3) cycle(1'b0, 4'd0, 7'd0);

    // valid held high: second word is only taken in the last bit cycle
    got0.delete();
    cycle(1'b1, 4'b1011, 7'd0);
    repeat (7) cycle(1'b1, 4'b0001, 7'd0);
    repeat (7) cycle(1'b0, 4'd0, 7'd0);
    pair = '0;
    for (int i = 1; i <= 14; i++) pair = {pair[12:0], got0[i]};
    chk("b2b", 32'(pair), 32'({7'b1011000, 7'b0001011}));
    repeat (3) cycle(1'b0, 4'd0, 7'd0);

    for (int k = 0; k < 7; k++) begin
      send_one(4'b1011, 7'd1 << k, rx);
      if (k == 3) chk("inj3", 32'(rx), 32'(7'b1010000));
      chk("inj.syn_nz", 32'(syndrome(rx) != 3'b000), 32'd1);
      chk("inj.fix", 32'(correct(rx)), 32'(7'b1011000));
      repeat (2) cycle(1'b0, 4'd0, 7'd0);
    end

    // reset during the 4th bit
    cycle(1'b1, 4'b0110, 7'd0);
    repeat (3) cycle(1'b0, 4'd0, 7'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.out", 32'(out0), 32'd0);
    chk("midrst.busy", 32'(busy0), 32'd0);
    chk("midrst.ready", 32'(ready0), 32'd0);
    chk("midrst.sof", 32'(sof0), 32'd0);
    chk("midrst.busy_g2", 32'(busy1), 32'd0);
    q0.delete(); q1.delete();
    cwm0 = '0; cwm1 = '0;
    @(negedge clk) reset = 1'b0;
    send_one(4'b0001, 7'd0, rx);
    chk("postrst", 32'(rx), 32'(7'b0001011));
    repeat (3) cycle(1'b0, 4'd0, 7'd0);

    repeat (600) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    e = 7'd0;
        2:       e = 7'd1 << $urandom_range(0, 6);
        default: e = 7'($urandom);
      endcase
      cycle(v, d, e);
    end
    repeat (12) cycle(1'b0, 4'd0, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
